// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequential load/store unit with byte-lane memory handshake and load formatting
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (misaligned accesses split into two beats instead of faulting)
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_fault,
  output logic                  stall_out,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [1:0] SZ_MAX = 2'(OFF_W);

  typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, RESP} state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                split_q, split_d;
  logic [NB-1:0]       be1_q, be1_d;
  logic [DATA_W-1:0]   wdata1_q, wdata1_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_fault_q, resp_fault_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [NB-1:0]       mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Request decode: lane offset, byte count, fault and split decisions.
  logic [OFF_W-1:0]    req_off;
  logic [3:0]          req_bytes;
  logic [NB-1:0]       lane_mask;
  logic [2*NB-1:0]     be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic                req_fault;
  logic                req_split;

  // Decode the incoming request into lane enables, shifted data and fault/split flags.
  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    req_bytes = 4'd1 << req_size;
    lane_mask = NB'((16'd1 << req_bytes) - 16'd1);
    be_wide   = {{NB{1'b0}}, lane_mask} << req_off;
    wd_wide   = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    req_fault = (req_size > SZ_MAX);
    req_split = (int'(req_off) + int'(req_bytes)) > NB;
`else
    req_fault = (req_size > SZ_MAX) | (|(req_off & OFF_W'(req_bytes - 4'd1)));
    req_split = 1'b0;
`endif
  end

  // Load formatting: merge beats, shift the addressed bytes down, then extend.
  logic [DATA_W-1:0] ld_lo;
  logic [DATA_W-1:0] ld_shifted;
  logic [DATA_W-1:0] ld_fmt;
  logic              ld_sign;
  int                ld_nbits;

  // Build the formatted load result from the beat(s) returned by memory.
  always_comb begin
    ld_lo      = split_q ? rd0_q : mem_rdata;
    ld_shifted = DATA_W'({mem_rdata, ld_lo} >> {off_q, 3'b000});
    ld_nbits   = 8 << size_q;
    case (size_q)
      2'd0:    ld_sign = ld_shifted[7];
      2'd1:    ld_sign = ld_shifted[15];
      2'd2:    ld_sign = ld_shifted[31];
      default: ld_sign = ld_shifted[DATA_W-1];
    endcase
    ld_sign = ld_sign & signed_q;
    ld_fmt  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_fmt[i] = (i < ld_nbits) ? ld_shifted[i] : ld_sign;
    end
  end

  // Next-state and next registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    split_d      = split_q;
    be1_d        = be1_q;
    wdata1_d     = wdata1_q;
    rd0_d        = rd0_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d    = req_is_store;
          size_d     = req_size;
          signed_d   = req_signed;
          off_d      = req_off;
          split_d    = req_split;
          be1_d      = be_wide[2*NB-1:NB];
          wdata1_d   = wd_wide[2*DATA_W-1:DATA_W];
          mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          if (req_fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d     = ISSUE0;
            mem_re_d    = ~req_is_store;
            mem_we_d    = req_is_store;
            mem_be_d    = be_wide[NB-1:0];
            mem_wdata_d = wd_wide[DATA_W-1:0];
          end
        end
      end
      ISSUE0: begin
        if (mem_ack) begin
          rd0_d = mem_rdata;
          if (split_q) begin
            state_d     = ISSUE1;
            mem_addr_d  = mem_addr_q + ADDR_W'(NB);
            mem_be_d    = be1_q;
            mem_wdata_d = wdata1_q;
          end else begin
            state_d      = RESP;
            mem_re_d     = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = store_q ? '0 : ld_fmt;
          end
        end
      end
      ISSUE1: begin
        if (mem_ack) begin
          state_d      = RESP;
          mem_re_d     = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = store_q ? '0 : ld_fmt;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      off_q        <= '0;
      split_q      <= 1'b0;
      be1_q        <= '0;
      wdata1_q     <= '0;
      rd0_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      split_q      <= split_d;
      be1_q        <= be1_d;
      wdata1_q     <= wdata1_d;
      rd0_q        <= rd0_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall_out  = ((state_q == IDLE) && req_valid) || (state_q == ISSUE0) || (state_q == ISSUE1);
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit at DATA_W 32 and 64
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        req_is_store, req_signed, v32, v64;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic        rdy32, rv32, f32, st32, re32, we32, ack32;
  logic [31:0] rd32, ma32, wd32, mrd32;
  logic [3:0]  be32;
  logic        rdy64, rv64, f64, st64, re64, we64, ack64;
  logic [63:0] rd64, wd64, mrd64;
  logic [31:0] ma64;
  logic [7:0]  be64;

  load_store_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clock(clock), .reset(reset), .req_valid(v32), .req_ready(rdy32),
    .req_is_store(req_is_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .resp_valid(rv32),
    .resp_rdata(rd32), .resp_fault(f32), .stall_out(st32), .mem_addr(ma32),
    .mem_re(re32), .mem_we(we32), .mem_be(be32), .mem_wdata(wd32),
    .mem_rdata(mrd32), .mem_ack(ack32));

  load_store_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clock(clock), .reset(reset), .req_valid(v64), .req_ready(rdy64),
    .req_is_store(req_is_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv64),
    .resp_rdata(rd64), .resp_fault(f64), .stall_out(st64), .mem_addr(ma64),
    .mem_re(re64), .mem_we(we64), .mem_be(be64), .mem_wdata(wd64),
    .mem_rdata(mrd64), .mem_ack(ack64));

  typedef struct { bit [31:0] addr; bit [7:0] be; bit we; bit [63:0] wdata; } beat_t;
  typedef struct { bit [63:0] rdata; bit fault; int lat; int acc; } resp_t;

  beat_t      beat_q[$];
  resp_t      resp_q[$];
  bit [7:0]   mem [bit [31:0]];
  int         checks = 0, passed = 0, cyc = 0, resp_seen = 0, cur_wait = 0;
  bit         sel64 = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit [7:0] mget(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  // Byte-level reference: which lanes each beat touches and what the load returns.
  task automatic model(input bit st, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                       input bit [63:0] wd, input int nb, input int w, output resp_t r);
    int bytes, off, nbeats, pos;
    bit [31:0] base;
    beat_t bt[2];
    bit [63:0] val;
    bytes = 1 << sz;
    off = int'(a % 32'(nb));
    r.acc = 0; r.rdata = 0; r.fault = 1'b0; r.lat = 1;
    if (bytes > nb || (!SPLIT_EN && (off % bytes) != 0)) begin
      r.fault = 1'b1;
      return;
    end
    nbeats = (off + bytes > nb) ? 2 : 1;
    base = a - 32'(off);
    for (int b = 0; b < 2; b++) begin
      bt[b].addr = base + 32'(b * nb); bt[b].be = 0; bt[b].we = st; bt[b].wdata = 0;
    end
    val = 0;
    for (int k = 0; k < bytes; k++) begin
      pos = off + k;
      bt[pos / nb].be[pos % nb] = 1'b1;
      bt[pos / nb].wdata[8 * (pos % nb) +: 8] = wd[8 * k +: 8];
      val[8 * k +: 8] = mget(a + 32'(k));
    end
    if (sg && bytes < nb && val[8 * bytes - 1]) val = val | ~((64'd1 << (8 * bytes)) - 64'd1);
    if (nb == 4) val[63:32] = 0;
    r.rdata = st ? 64'd0 : val;
    r.lat = nbeats * (w + 1) + 1;
    for (int b = 0; b < nbeats; b++) beat_q.push_back(bt[b]);
  endtask

  // Memory responder: acks each beat after cur_wait cycles and checks it against the beat queue.
  initial begin
    bit fresh, ack, s_re, s_we;
    int wcnt, nb;
    logic [63:0] rdat, s_wd, bmask;
    logic [31:0] s_addr;
    logic [7:0] s_be;
    beat_t e;
    fresh = 1'b1; wcnt = 0;
    ack32 = 0; ack64 = 0; mrd32 = 0; mrd64 = 0;
    forever begin
      @(negedge clock);
      nb = sel64 ? 8 : 4;
      s_re = sel64 ? re64 : re32;
      s_we = sel64 ? we64 : we32;
      s_addr = sel64 ? ma64 : ma32;
      s_be = sel64 ? be64 : {4'b0, be32};
      s_wd = sel64 ? wd64 : {32'b0, wd32};
      if (sel64 ? (re32 | we32) : (re64 | we64)) check(1'b0, "idle_dut_strobe", 1, 0);
      ack = 1'b0; rdat = 0;
      if (!(s_re || s_we)) begin
        fresh = 1'b1;
        ack = ($urandom_range(0, 3) == 0);
        rdat = {$urandom, $urandom};
      end else begin
        if (fresh) begin wcnt = cur_wait; fresh = 1'b0; end
        if (wcnt == 0) begin
          ack = 1'b1; fresh = 1'b1;
          for (int j = 0; j < nb; j++) rdat[8 * j +: 8] = mget(s_addr + 32'(j));
          if (beat_q.size() == 0) check(1'b0, "unexpected_beat", {32'b0, s_addr}, 0);
          else begin
            e = beat_q.pop_front();
            bmask = 0;
            for (int j = 0; j < 8; j++) if (e.be[j]) bmask[8 * j +: 8] = 8'hFF;
            check(s_addr == e.addr, "beat_addr", {32'b0, s_addr}, {32'b0, e.addr});
            check(s_be == e.be, "beat_be", {56'b0, s_be}, {56'b0, e.be});
            check({s_we, s_re} == {e.we, ~e.we}, "beat_dir", {62'b0, s_we, s_re}, {62'b0, e.we, ~e.we});
            if (e.we) check((s_wd & bmask) == (e.wdata & bmask), "beat_wdata", s_wd & bmask, e.wdata & bmask);
          end
          if (s_we) for (int j = 0; j < nb; j++) if (s_be[j]) mem[s_addr + 32'(j)] = s_wd[8 * j +: 8];
        end else begin
          wcnt--;
        end
      end
      ack32 = ack; ack64 = ack;
      mrd32 = rdat[31:0]; mrd64 = rdat;
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid of the active unit.
  initial begin
    resp_t r;
    logic [63:0] act;
    logic fa;
    forever begin
      @(negedge clock);
      #1;
      if (sel64 ? rv32 : rv64) check(1'b0, "idle_dut_resp", 1, 0);
      if (sel64 ? rv64 : rv32) begin
        if (resp_q.size() == 0) check(1'b0, "unexpected_resp", 1, 0);
        else begin
          r = resp_q.pop_front();
          act = sel64 ? rd64 : {32'b0, rd32};
          fa = sel64 ? f64 : f32;
          check(act == r.rdata, "resp_rdata", act, r.rdata);
          check(fa == r.fault, "resp_fault", {63'b0, fa}, {63'b0, r.fault});
          check(cyc - r.acc == r.lat, "resp_latency", 64'(cyc - r.acc), 64'(r.lat));
        end
        resp_seen++;
      end
    end
  end

  task automatic issue(input bit st, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                       input bit [63:0] wd, input int w, input bit s64,
                       input bit use_exp, input bit [63:0] er, input bit ef);
    resp_t r;
    int seen0, stall_cnt;
    bit done;
    @(negedge clock);
    sel64 = s64; cur_wait = w;
    model(st, sz, sg, a, wd, s64 ? 8 : 4, w, r);
    if (use_exp) begin r.rdata = er; r.fault = ef; end
    r.acc = cyc;
    resp_q.push_back(r);
    seen0 = resp_seen;
    req_is_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    v32 = ~s64; v64 = s64;
    #1;
    check((s64 ? rdy64 : rdy32) == 1'b1, "req_ready_idle", {63'b0, s64 ? rdy64 : rdy32}, 1);
    stall_cnt = (s64 ? st64 : st32) ? 1 : 0;
    @(negedge clock);
    v32 = 0; v64 = 0;
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom); req_signed = 1'($urandom); req_is_store = 1'($urandom);
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      #2;
      if (resp_seen != seen0) begin
        done = 1'b1;
        check((s64 ? st64 : st32) == 1'b0, "stall_in_resp", {63'b0, s64 ? st64 : st32}, 0);
      end else begin
        if (s64 ? st64 : st32) stall_cnt++;
        @(negedge clock);
      end
    end
    if (!done) begin check(1'b0, "resp_timeout", 0, 1); resp_q.delete(); end
    check(stall_cnt == r.lat, "stall_cycles", 64'(stall_cnt), 64'(r.lat));
    check(beat_q.size() == 0, "beats_done", 64'(beat_q.size()), 0);
    beat_q.delete();
  endtask

  task automatic reset_mid_access();
    resp_t r;
    int seen0;
    @(negedge clock);
    sel64 = 1'b0; cur_wait = 30;
    model(1'b0, 2'd2, 1'b0, 32'h40, 64'd0, 4, 30, r);
    seen0 = resp_seen;
    req_is_store = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h40; req_wdata = 0;
    v32 = 1;
    @(negedge clock);
    v32 = 0;
    #1;
    check(re32 == 1'b1, "rst_pre_strobe", {63'b0, re32}, 1);
    reset = 0;
    @(negedge clock);
    #1;
    check(re32 == 1'b0, "rst_strobe_drop", {63'b0, re32}, 0);
    check(rdy32 == 1'b1, "rst_ready", {63'b0, rdy32}, 1);
    reset = 1;
    repeat (4) @(negedge clock);
    #2;
    check(resp_seen == seen0, "rst_no_resp", 64'(resp_seen), 64'(seen0));
    beat_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit [31:0] a;
    reset = 0; v32 = 0; v64 = 0;
    req_is_store = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clock);
    #1;
    check(rdy32 && !st32 && rdy64 && !st64, "rst_ready_stall", {60'b0, rdy32, st32, rdy64, st64}, 64'hA);
    check(!rv32 && !f32 && rd32 == 0, "rst_resp32", {30'b0, rv32, f32, rd32}, 0);
    check(!re32 && !we32 && be32 == 0, "rst_strobe32", {58'b0, re32, we32, be32}, 0);
    check(ma32 == 0 && wd32 == 0, "rst_bus32", {ma32, wd32}, 0);
    check(!rv64 && !f64 && rd64 == 0 && !re64 && !we64 && be64 == 0, "rst_resp64", rd64, 0);
    check(ma64 == 0 && wd64 == 0, "rst_bus64", wd64, 0);
    reset = 1;

    mem[32'h1000] = 8'h34; mem[32'h1001] = 8'h12; mem[32'h1002] = 8'hFF; mem[32'h1003] = 8'h80;
    for (int i = 0; i < 8; i++) mem[32'h4 + 32'(i)] = 8'h11 * 8'(i + 1);
    for (int i = 0; i < 7; i++) mem[32'h10 + 32'(i)] = 8'(i + 1);
    mem[32'h17] = 8'h9A;

    issue(1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 0, 1'b0, 1'b1, 64'hFFFF_FF80, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h2002, 64'h0000_BEEF, 3, 1'b0, 1'b1, 64'd0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h0001, 64'd0, 0, 1'b0, ~SPLIT_EN, 64'd0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h0008, 64'd0, 0, 1'b0, 1'b1, 64'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h0006, 64'd0, 1, 1'b0, 1'b1, SPLIT_EN ? 64'h6655_4433 : 64'd0, ~SPLIT_EN);
    reset_mid_access();
    issue(1'b0, 2'd3, 1'b0, 32'h0010, 64'd0, 0, 1'b1, 1'b1, 64'h9A07_0605_0403_0201, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h0017, 64'd0, 1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9A, 1'b0);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 255));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom},
            $urandom_range(0, 2), 1'($urandom), 1'b0, 64'd0, 1'b0);
    end

    repeat (3) @(negedge clock);
    check(resp_q.size() == 0, "resp_queue_empty", 64'(resp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
